// File: rtl/char_buf_pkg.sv
// Shared definitions for the VGA character-buffer read engine.
// Holds FSM state codes, word packing constants and the char code type.
package char_buf_pkg;

    localparam int CHARS_PER_WORD = 4;
    localparam int ADDR_W_DEF     = 11;

    typedef logic [7:0] char_t;
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/char_word_fifo.sv
// Show-ahead synchronous word FIFO for prefetched SRAM words.
// Ports: clk, reset (sync, high), push/wdata, pop, rdata (head), count.
module char_word_fifo
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [31:0]              wdata,
    input  logic                     pop,
    output logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/char_buf_sram_reader.sv
// Scans the character-buffer SRAM via port s2 and streams char codes out.
// Ports: clk/reset, enable, sram s2 master, Avalon-ST source
// (st_data/valid/ready/sop/eop/line), busy.
// Option: CHAR_READER_ROW_REPEAT_EN re-emits each row LINES times.
module char_buf_sram_reader
    import char_buf_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int STRIDE_W   = 32,
    parameter int BASE_W     = 0,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int LINES      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] sram_address2,
    output logic              sram_chipselect2,
    output logic              sram_clken2,
    output logic              sram_write2,
    output logic [3:0]        sram_byteenable2,
    input  logic [31:0]       sram_readdata2,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic [2:0]        st_line,
    output logic              busy
);

    localparam int WPR = COLS / CHARS_PER_WORD;
`ifdef CHAR_READER_ROW_REPEAT_EN
    localparam int NLINES = LINES;
`else
    localparam int NLINES = 1;
`endif
    localparam int WC_W  = $clog2(WPR + 1);
    localparam int OC_W  = $clog2(COLS + 1);
    localparam int R_W   = $clog2(ROWS + 1);
    localparam int L_W   = $clog2(NLINES + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if ((COLS % CHARS_PER_WORD) != 0 || LINES < 1 || LINES > 8) begin : g_bad_cfg
        $error("char_buf_sram_reader: COLS must be a multiple of 4, LINES 1..8");
    end

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcol_q, wcol_d;
    logic [R_W-1:0]   row_q, row_d;
    logic [L_W-1:0]   iline_q, iline_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic             inflight_q;
    logic [OC_W-1:0]  ocol_q, ocol_d;
    logic [R_W-1:0]   orow_q, orow_d;
    logic [L_W-1:0]   oline_q, oline_d;

    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_rdata;
    logic [CNT_W:0]   used;
    logic             credit_ok;
    logic             issue;
    logic             last_word;
    logic             hs;
    logic             pop;
    logic             o_last_col;
    logic             o_last_line;
    logic             o_last_row;
    char_t            char_sel;

    // Words issued but not yet popped must never exceed the FIFO size.
    assign used      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok = used < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = (state_q == ST_RUN) && credit_ok;
    assign last_word = (wcol_q == WC_W'(WPR - 1))
                    && (iline_q == L_W'(NLINES - 1))
                    && (row_q == R_W'(ROWS - 1));

    assign o_last_col  = ocol_q == OC_W'(COLS - 1);
    assign o_last_line = oline_q == L_W'(NLINES - 1);
    assign o_last_row  = orow_q == R_W'(ROWS - 1);

    assign st_valid = fifo_count != '0;
    assign hs       = st_valid && st_ready;
    // A word leaves the FIFO on the handshake of its top byte.
    assign pop      = hs && (ocol_q[1:0] == 2'd3);

    assign sram_address2    = row_base_q + ADDR_W'(wcol_q);
    assign sram_chipselect2 = issue;
    assign sram_clken2      = 1'b1;
    assign sram_write2      = 1'b0;
    assign sram_byteenable2 = 4'hF;
    assign busy             = state_q != ST_IDLE;

    always_comb begin
        char_sel = '0;
        unique case (ocol_q[1:0])
            2'd0: char_sel = fifo_rdata[7:0];
            2'd1: char_sel = fifo_rdata[15:8];
            2'd2: char_sel = fifo_rdata[23:16];
            2'd3: char_sel = fifo_rdata[31:24];
        endcase
    end

    assign st_data = st_valid ? char_sel : '0;
    assign st_sop  = st_valid && (ocol_q == '0)
                  && (oline_q == '0) && (orow_q == '0);
    assign st_eop  = st_valid && o_last_col && o_last_line && o_last_row;
`ifdef CHAR_READER_ROW_REPEAT_EN
    assign st_line = 3'(oline_q);
`else
    assign st_line = 3'd0;
`endif

    // Issue and output counters wrap to zero at frame end, so each new
    // frame starts from row 0 without a separate clear.
    always_comb begin
        state_d    = state_q;
        wcol_d     = wcol_q;
        row_d      = row_q;
        iline_d    = iline_q;
        row_base_d = row_base_q;
        ocol_d     = ocol_q;
        orow_d     = orow_q;
        oline_d    = oline_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_word) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hs && st_eop) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            if (wcol_q == WC_W'(WPR - 1)) begin
                wcol_d = '0;
                if (iline_q == L_W'(NLINES - 1)) begin
                    iline_d = '0;
                    if (row_q == R_W'(ROWS - 1)) begin
                        row_d      = '0;
                        row_base_d = ADDR_W'(BASE_W);
                    end else begin
                        row_d      = row_q + R_W'(1);
                        row_base_d = row_base_q + ADDR_W'(STRIDE_W);
                    end
                end else begin
                    iline_d = iline_q + L_W'(1);
                end
            end else begin
                wcol_d = wcol_q + WC_W'(1);
            end
        end

        if (hs) begin
            if (o_last_col) begin
                ocol_d = '0;
                if (o_last_line) begin
                    oline_d = '0;
                    orow_d  = o_last_row ? '0 : orow_q + R_W'(1);
                end else begin
                    oline_d = oline_q + L_W'(1);
                end
            end else begin
                ocol_d = ocol_q + OC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wcol_q     <= '0;
            row_q      <= '0;
            iline_q    <= '0;
            row_base_q <= ADDR_W'(BASE_W);
            inflight_q <= 1'b0;
            ocol_q     <= '0;
            orow_q     <= '0;
            oline_q    <= '0;
        end else begin
            state_q    <= state_d;
            wcol_q     <= wcol_d;
            row_q      <= row_d;
            iline_q    <= iline_d;
            row_base_q <= row_base_d;
            inflight_q <= issue;
            ocol_q     <= ocol_d;
            orow_q     <= orow_d;
            oline_q    <= oline_d;
        end
    end

    // Read latency is one cycle: the word issued last cycle is on
    // readdata2 now and is captured directly.
    char_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .wdata (sram_readdata2),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_char_buf_sram_reader.sv
// Scoreboard bench for char_buf_sram_reader with a 1-cycle SRAM model.
// Small 8x2 frame; checks data, sop/eop, addresses, credit and stalls.
module tb_char_buf_sram_reader;

    localparam int COLS   = 8;
    localparam int ROWS   = 2;
    localparam int STRIDE = 32;
    localparam int DEPTH  = 4;
`ifdef CHAR_READER_ROW_REPEAT_EN
    localparam int NL = 8;
`else
    localparam int NL = 1;
`endif
    localparam int FRAME = COLS * ROWS * NL;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [2:0] line;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [10:0] sram_address2;
    logic        sram_chipselect2;
    logic        sram_clken2;
    logic        sram_write2;
    logic [3:0]  sram_byteenable2;
    logic [31:0] sram_readdata2 = '0;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_ready = 1'b1;
    logic        st_sop;
    logic        st_eop;
    logic [2:0]  st_line;
    logic        busy;

    logic        ready_force = 1'b1;
    logic        stall_mode  = 1'b0;
    logic [15:0] pat = 16'b1011_0111_1101_1010;

    exp_t        exp_q[$];
    logic [10:0] addr_q[$];
    int          passed = 0;
    int          total  = 0;
    int          issued = 0;
    int          popped = 0;
    int          hs_cnt = 0;
    logic        prev_stall = 1'b0;
    exp_t        held;

    always #5 clk = ~clk;

    char_buf_sram_reader #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .STRIDE_W   (STRIDE),
        .BASE_W     (0),
        .ADDR_W     (11),
        .FIFO_DEPTH (DEPTH),
        .LINES      (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sram_address2    (sram_address2),
        .sram_chipselect2 (sram_chipselect2),
        .sram_clken2      (sram_clken2),
        .sram_write2      (sram_write2),
        .sram_byteenable2 (sram_byteenable2),
        .sram_readdata2   (sram_readdata2),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_sop           (st_sop),
        .st_eop           (st_eop),
        .st_line          (st_line),
        .busy             (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // SRAM word k holds bytes k, k+1, k+2, k+3 (low byte first).
    always @(posedge clk) begin
        logic [7:0] a;
        a = sram_address2[7:0];
        if (sram_chipselect2)
            sram_readdata2 <= {a + 8'd3, a + 8'd2, a + 8'd1, a};
    end

    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            st_ready = pat[0];
            pat = {pat[0], pat[15:1]};
        end else begin
            st_ready = ready_force;
        end
    end

    // Words outstanding = issued - popped, tracked from the ports only.
    always @(posedge clk) begin
        if (reset) begin
            issued <= 0;
            popped <= 0;
            hs_cnt <= 0;
        end else begin
            if (sram_chipselect2) issued <= issued + 1;
            if (st_valid && st_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (hs_cnt % 4 == 3) popped <= popped + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (sram_chipselect2) begin
                chk("credit", 32'(issued - popped < DEPTH), 1);
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", 32'(sram_address2), 32'(addr_q.pop_front()));
            end
            if (prev_stall && st_valid)
                chk("stall_hold", 32'({st_data, st_sop, st_eop, st_line}),
                    32'(held));
            prev_stall = st_valid && !st_ready;
            held = {st_data, st_sop, st_eop, st_line};
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) chk("extra_char", 1, 0);
                else chk("char", 32'({st_data, st_sop, st_eop, st_line}),
                         32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_frame();
        exp_t        e;
        logic [10:0] a;
        logic [7:0]  lo;
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < NL; l++)
                for (int w = 0; w < COLS / 4; w++) begin
                    a = 11'(r * STRIDE + w);
                    lo = a[7:0];
                    addr_q.push_back(a);
                    for (int b = 0; b < 4; b++) begin
                        e.d    = lo + 8'(b);
                        e.sop  = (r == 0 && l == 0 && w == 0 && b == 0);
                        e.eop  = (r == ROWS - 1 && l == NL - 1 &&
                                  w == COLS / 4 - 1 && b == 3);
                        e.line = 3'(l);
                        exp_q.push_back(e);
                    end
                end
    endtask

    task automatic wait_left(input int left, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(posedge clk);
            if (exp_q.size() <= left && (left > 0 || addr_q.size() == 0))
                ok = 1;
        end
        if (!ok) chk("timeout", 0, 1);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", st_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cs", sram_chipselect2, 0);
        chk("rst_clken", sram_clken2, 1);
        chk("rst_write", sram_write2, 0);
        chk("rst_be", sram_byteenable2, 4'hF);
        chk("rst_sop_eop", {st_sop, st_eop}, 0);
        chk("rst_data", st_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single pulse: one frame, first read the cycle after sampling.
        push_frame();
        pulse_enable();
        @(negedge clk);
        chk("cs_latency", sram_chipselect2, 1);
        chk("busy_run", busy, 1);
        wait_left(0, 300);
        @(negedge clk);
        chk("busy_fall", busy, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_valid", st_valid, 0);
        chk("idle_busy", busy, 0);

        // Held enable with a stall pattern: two back-to-back frames.
        stall_mode = 1'b1;
        push_frame();
        push_frame();
        enable = 1'b1;
        wait_left(FRAME, 1000);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("busy_frame2", busy, 1);
        wait_left(0, 1000);
        @(negedge clk);
        chk("busy_fall2", busy, 0);
        stall_mode = 1'b0;
        @(posedge clk);

        // Reset mid-row, then a clean restart from address 0.
        ready_force = 1'b1;
        push_frame();
        pulse_enable();
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", st_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cs", sram_chipselect2, 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        push_frame();
        pulse_enable();
        wait_left(0, 300);
        @(negedge clk);
        chk("busy_fall3", busy, 0);

        repeat (5) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size() + addr_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
